rc_manager: RTL



---
 rtl/rc_pkg.sv | 17 +
 rtl/rc_timer.sv | 31 +++
 rtl/rc_manager.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rc_pkg.sv
// Shared types and default constants for the reconfiguration controller.
package rc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SETTLE,
    LOAD,
    RESET,
    RELEASE
  } rc_state_t;

  localparam int DEF_ACK_TIMEOUT   = 1024;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_RST_CYCLES    = 4;

endpackage

// File: rtl/rc_timer.sv
// Loadable counter shared by the controller states: counts up towards UP_LIMIT
// for the acknowledge timeout and down towards zero for the hold intervals.
module rc_timer #(
  parameter int WIDTH    = 11,
  parameter int UP_LIMIT = 1023
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             up,
  output logic             tc
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en) begin
      count_reg <= up ? count_reg + WIDTH'(1) : count_reg - WIDTH'(1);
    end
  end

  // Terminal count depends on the direction the current state uses.
  assign tc = up ? (count_reg == WIDTH'(UP_LIMIT)) : (count_reg == '0);

endmodule

// File: rtl/rc_manager.sv
// Sequences one partial reconfiguration: stop handshake, isolation, bitstream
// load, module reset and reconnection. All outputs are registered.
module rc_manager
  import rc_pkg::*;
#(
  parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int RST_CYCLES    = DEF_RST_CYCLES
) (
  input  logic clk,
  input  logic rstn,
  input  logic rc_start,
  output logic rc_busy,
  output logic rc_done,
  output logic rc_err,
  output logic rc_reqn,
  input  logic rc_ackn,
  output logic is_reconfn,
  output logic cfg_start,
  input  logic cfg_done,
  output logic rr_rstn
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  rc_state_t state_reg, state_next;

  logic rc_busy_reg, rc_busy_next;
  logic rc_done_reg, rc_done_next;
  logic rc_err_reg, rc_err_next;
  logic rc_reqn_reg, rc_reqn_next;
  logic is_reconfn_reg, is_reconfn_next;
  logic cfg_start_reg, cfg_start_next;
  logic rr_rstn_reg, rr_rstn_next;

  logic          tmr_load;
  logic [CW-1:0] tmr_load_value;
  logic          tmr_en;
  logic          tmr_up;
  logic          tmr_tc;

  rc_timer #(
    .WIDTH    (CW),
    .UP_LIMIT (ACK_TIMEOUT - 1)
  ) u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .en         (tmr_en),
    .up         (tmr_up),
    .tc         (tmr_tc)
  );

  always_comb begin
    state_next      = state_reg;
    rc_busy_next    = 1'b1;
    rc_done_next    = 1'b0;
    rc_err_next     = 1'b0;
    rc_reqn_next    = 1'b1;
    is_reconfn_next = 1'b1;
    cfg_start_next  = 1'b0;
    rr_rstn_next    = 1'b1;
    tmr_load        = 1'b0;
    tmr_load_value  = '0;
    tmr_en          = 1'b0;
    tmr_up          = 1'b0;

    case (state_reg)
      IDLE: begin
        rc_busy_next = 1'b0;
        if (rc_start) begin
          state_next   = REQ;
          rc_busy_next = 1'b1;
          rc_reqn_next = 1'b0;
          tmr_load     = 1'b1;
        end
      end

      REQ: begin
        tmr_up = 1'b1;
        // Acknowledge is checked first so it wins on the terminal-count cycle.
        if (!rc_ackn) begin
          state_next      = SETTLE;
          is_reconfn_next = 1'b0;
          tmr_load        = 1'b1;
          tmr_load_value  = CW'(SETTLE_CYCLES - 1);
        end else if (tmr_tc) begin
          state_next   = IDLE;
          rc_busy_next = 1'b0;
          rc_err_next  = 1'b1;
        end else begin
          rc_reqn_next = 1'b0;
          tmr_en       = 1'b1;
        end
      end

      SETTLE: begin
        is_reconfn_next = 1'b0;
        if (tmr_tc) begin
          state_next     = LOAD;
          cfg_start_next = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end

      LOAD: begin
        is_reconfn_next = 1'b0;
        if (cfg_done) begin
          state_next     = RESET;
          rr_rstn_next   = 1'b0;
          tmr_load       = 1'b1;
          tmr_load_value = CW'(RST_CYCLES - 1);
        end
      end

      RESET: begin
        is_reconfn_next = 1'b0;
        if (tmr_tc) begin
          state_next = RELEASE;
        end else begin
          rr_rstn_next = 1'b0;
          tmr_en       = 1'b1;
        end
      end

      RELEASE: begin
        // The module has been out of reset for a cycle; reconnect it now.
        state_next   = IDLE;
        rc_busy_next = 1'b0;
        rc_done_next = 1'b1;
      end

      default: begin
        state_next   = IDLE;
        rc_busy_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      rc_busy_reg    <= 1'b0;
      rc_done_reg    <= 1'b0;
      rc_err_reg     <= 1'b0;
      rc_reqn_reg    <= 1'b1;
      is_reconfn_reg <= 1'b1;
      cfg_start_reg  <= 1'b0;
      rr_rstn_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rc_busy_reg    <= rc_busy_next;
      rc_done_reg    <= rc_done_next;
      rc_err_reg     <= rc_err_next;
      rc_reqn_reg    <= rc_reqn_next;
      is_reconfn_reg <= is_reconfn_next;
      cfg_start_reg  <= cfg_start_next;
      rr_rstn_reg    <= rr_rstn_next;
    end
  end

  assign rc_busy    = rc_busy_reg;
  assign rc_done    = rc_done_reg;
  assign rc_err     = rc_err_reg;
  assign rc_reqn    = rc_reqn_reg;
  assign is_reconfn = is_reconfn_reg;
  assign cfg_start  = cfg_start_reg;
  assign rr_rstn    = rr_rstn_reg;

endmodule
